rnn_stream_driver: RTL and testbench

RNN_STREAM_DRIVER -- requirements
Module: rnn_stream_driver

---
 rtl/rnn_stream_driver.sv | 159 +++++++++++++++
 tb/tb_rnn_stream_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_stream_driver.sv
// Streams fixed-width words into a parallel RNN input vector, waits out the network latency,
// then presents the network result on a valid/ready port. Optional step counter: RNN_DRV_STEPCNT_EN.
module rnn_stream_driver #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int NUM_IN      = 3,
    parameter int LATENCY     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [NUM_IN*DATA_WIDTH-1:0] net_in,
    input  logic [DATA_WIDTH-1:0]        net_out,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic                         busy
`ifdef RNN_DRV_STEPCNT_EN
    ,
    output logic [15:0]                  step_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = 4;

    // Data is passed through untouched, so the fraction width only needs to be sane.
    if (FRACT_WIDTH < 0 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_fract
        $error("rnn_stream_driver: FRACT_WIDTH must lie within 0..DATA_WIDTH");
    end
    if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
        $error("rnn_stream_driver: NUM_IN must lie within 2..8");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("rnn_stream_driver: LATENCY must lie within 1..15");
    end

    typedef enum logic [1:0] {
        COLLECT,
        APPLY,
        EMIT
    } state_t;

    state_t                         state_q;
    logic [IDX_W-1:0]               idx_q;
    logic [CNT_W-1:0]               wait_q;
    logic [DATA_WIDTH-1:0]          stage_q [NUM_IN];
    logic [NUM_IN*DATA_WIDTH-1:0]   net_in_q;
    logic [NUM_IN*DATA_WIDTH-1:0]   vec_d;
    logic [DATA_WIDTH-1:0]          m_data_q;
    logic                           m_valid_q;
    logic                           m_last_q;
    logic                           last_q;
    logic                           s_ready_q;
    logic                           busy_q;

    logic accept;
    logic last_slot;
    logic emit_hs;

    assign accept    = s_valid & s_ready_q;
    assign last_slot = (idx_q == IDX_W'(NUM_IN - 1));
    assign emit_hs   = m_valid_q & m_ready;

    // Full vector = staged words plus the word arriving on the final slot.
    for (genvar gi = 0; gi < NUM_IN - 1; gi++) begin : g_vec
        assign vec_d[gi*DATA_WIDTH +: DATA_WIDTH] = stage_q[gi];
    end
    assign vec_d[(NUM_IN-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            wait_q    <= '0;
            net_in_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            last_q    <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (last_slot) begin
                            net_in_q  <= vec_d;
                            last_q    <= s_last;
                            idx_q     <= '0;
                            wait_q    <= CNT_W'(LATENCY);
                            state_q   <= APPLY;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            stage_q[idx_q] <= s_data;
                            idx_q          <= idx_q + 1'b1;
                            busy_q         <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    // A count of one means this edge is LATENCY edges after net_in moved.
                    if (wait_q == CNT_W'(1)) begin
                        m_data_q  <= net_out;
                        m_last_q  <= last_q;
                        m_valid_q <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= EMIT;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                EMIT: begin
                    if (emit_hs) begin
                        m_valid_q <= 1'b0;
                        state_q   <= COLLECT;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign net_in  = net_in_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;

`ifdef RNN_DRV_STEPCNT_EN
    logic [15:0] step_cnt_q;

    // Counts emitted steps within a sequence; the closing vector resets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt_q <= '0;
        end else if (emit_hs) begin
            step_cnt_q <= m_last_q ? 16'd0 : step_cnt_q + 16'd1;
        end
    end

    assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_rnn_stream_driver.sv
// Scoreboard bench for rnn_stream_driver: directed vectors, a latency-windowed net model,
// and a monitor that checks every emitted result against the expected queue.
module tb_rnn_stream_driver;

    localparam int DW  = 16;
    localparam int NI  = 3;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [NI*DW-1:0] net_in;
    logic [DW-1:0]    net_out;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready = 1'b1;
    logic             busy;
`ifdef RNN_DRV_STEPCNT_EN
    logic [15:0]      step_cnt;
`endif

    rnn_stream_driver #(
        .DATA_WIDTH (DW),
        .FRACT_WIDTH(8),
        .NUM_IN     (NI),
        .LATENCY    (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .net_in  (net_in),
        .net_out (net_out),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .busy    (busy)
`ifdef RNN_DRV_STEPCNT_EN
        ,
        .step_cnt(step_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t sb[$];
    int   hs_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Net model: result is only valid in the cycle before the correct sampling edge.
    logic [NI*DW-1:0] prev_in = '0;
    int               age = 0;
    initial forever begin
        @(negedge clk);
        if (net_in !== prev_in) begin
            prev_in = net_in;
            age = 0;
        end else begin
            age++;
        end
    end
    assign net_out = (age == LAT - 1) ? (net_in[15:0] + net_in[31:16] + net_in[47:32]) : 16'hDEAD;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got data 0x%0h with no expected entry", m_data);
            end else begin
                e = sb.pop_front();
                chk("m_data", 64'(m_data), 64'(e.d));
                chk("m_last", 64'(m_last), 64'(e.l));
                hs_q.push_back(cyc);
                $display("result data=0x%04h last=%0d at cycle %0d", m_data, m_last, cyc);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        int t = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 60) begin
                chk("send_timeout", 64'(s_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
    endtask

    task automatic expect_result(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int diff;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_net_in",  64'(net_in),  64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_s_ready", 64'(s_ready), 64'd1);

        // V1: back-to-back words, latency and m_valid timing
        expect_result(16'h0600, 1'b0);
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        chk("v1_net_in_partial", 64'(net_in), 64'd0);
        send(16'h0300, 1'b0);
        @(negedge clk);
        chk("v1_net_in", 64'(net_in), 64'h0300_0200_0100);
        chk("v1_m_valid_n0", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("v1_m_valid_n1", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("v1_m_valid_n2", 64'(m_valid), 64'd1);
        chk("v1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("v1_m_valid_after_hs", 64'(m_valid), 64'd0);
        chk("v1_s_ready_after_hs", 64'(s_ready), 64'd1);
        drain("v1_drain");
`ifdef RNN_DRV_STEPCNT_EN
        chk("step_cnt_1", 64'(step_cnt), 64'd1);
`endif

        // V2: backpressure, result held stable for 5 cycles
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        expect_result(16'h0A80, 1'b0);
        send(16'h0800, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0080, 1'b0);
        for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
        chk("v2_m_valid_rise", 64'(m_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("v2_hold_m_valid", 64'(m_valid), 64'd1);
            chk("v2_hold_m_data",  64'(m_data),  64'h0A80);
            chk("v2_hold_s_ready", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain("v2_drain");
`ifdef RNN_DRV_STEPCNT_EN
        chk("step_cnt_2", 64'(step_cnt), 64'd2);
`endif

        // V3/V4: s_last ignored on word 0, honoured on word 2; throughput
        expect_result(16'h0060, 1'b0);
        expect_result(16'h0007, 1'b1);
        send(16'h0010, 1'b1);
        send(16'h0020, 1'b0);
        send(16'h0030, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0004, 1'b1);
        drain("v34_drain");
        diff = (hs_q.size() >= 2) ? hs_q[hs_q.size()-1] - hs_q[hs_q.size()-2] : -1;
        chk("v34_period", 64'(diff), 64'(NI + LAT + 1));
`ifdef RNN_DRV_STEPCNT_EN
        chk("step_cnt_clear", 64'(step_cnt), 64'd0);
`endif

        // V5: s_valid toggling every other cycle
        expect_result(16'h6666, 1'b0);
        send(16'h1111, 1'b0);
        chk("v5_net_in_w0", 64'(net_in), 64'h0004_0002_0001);
        @(posedge clk);
        #1;
        send(16'h2222, 1'b0);
        chk("v5_net_in_w1", 64'(net_in), 64'h0004_0002_0001);
        @(posedge clk);
        #1;
        send(16'h3333, 1'b0);
        @(negedge clk);
        chk("v5_net_in", 64'(net_in), 64'h3333_2222_1111);
        drain("v5_drain");

        // V6: reset mid-vector discards the partial vector
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        chk("v6_busy_partial", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("v6_rst_s_ready", 64'(s_ready), 64'd0);
        chk("v6_rst_busy",    64'(busy),    64'd0);
        chk("v6_rst_m_valid", 64'(m_valid), 64'd0);
        chk("v6_rst_net_in",  64'(net_in),  64'd0);
        chk("v6_rst_m_data",  64'(m_data),  64'd0);
        chk("v6_rst_m_last",  64'(m_last),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("v6_s_ready_rise", 64'(s_ready), 64'd1);
        expect_result(16'h0012, 1'b0);
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        @(negedge clk);
        chk("v6_net_in", 64'(net_in), 64'h0007_0006_0005);
        drain("v6_drain");
`ifdef RNN_DRV_STEPCNT_EN
        chk("step_cnt_after_rst", 64'(step_cnt), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
